// File: rtl/i2c_pin_filter_if.sv
// I2C pin filter bus bundle: raw pins and glitch clear in, filtered lines,
// edge/condition flags, bus state and glitch count out.
interface i2c_pin_filter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 scl_in;
    logic                 sda_in;
    logic                 glitch_clr;
    logic                 scl_filt;
    logic                 sda_filt;
    logic                 scl_rise;
    logic                 scl_fall;
    logic                 start_det;
    logic                 stop_det;
    logic                 bus_busy;
    logic [CNT_WIDTH-1:0] glitch_cnt;

    // Pin driver side (board model or bench)
    modport master (
        output scl_in, sda_in, glitch_clr,
        input  scl_filt, sda_filt, scl_rise, scl_fall,
        input  start_det, stop_det, bus_busy, glitch_cnt
    );

    // Filter side
    modport slave (
        input  scl_in, sda_in, glitch_clr,
        output scl_filt, sda_filt, scl_rise, scl_fall,
        output start_det, stop_det, bus_busy, glitch_cnt
    );
endinterface

// File: rtl/i2c_pin_filter.sv
// I2C front end: synchronizes raw SCL/SDA, rejects pulses shorter than
// FILTER_CYCLES clocks, flags SCL edges and START/STOP, tracks bus busy
// and keeps a saturating count of rejected glitches.
module i2c_pin_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input logic            clk,
    input logic            rst,
    i2c_pin_filter_if.slave bus
);
    localparam int FCW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FCW-1:0] CNT_LAST = FCW'(FILTER_CYCLES - 1);

    // Index 0 is SCL, index 1 is SDA throughout.
    logic [1:0] pin_s;
    logic [1:0] filt_s;
    logic [1:0] reject_s;
    logic [1:0] prev_r;

    logic                 busy_r;
    logic [CNT_WIDTH-1:0] glitch_cnt_r;
    logic [CNT_WIDTH-1:0] glitch_nxt_s;
    logic [CNT_WIDTH:0]   glitch_sum_s;
    logic [1:0]           glitch_inc_s;

    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    assign pin_s = {bus.sda_in, bus.scl_in};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   sync_s;
        logic                   filt_r;
        logic                   filt_nxt_s;
        logic [FCW-1:0]         cnt_r;
        logic [FCW-1:0]         cnt_nxt_s;
        logic                   rej_s;

        // Synchronizer chain; resets to the idle-bus level
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_r <= {SYNC_STAGES{1'b1}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], pin_s[i]};
            end
        end

        assign sync_s = sync_r[SYNC_STAGES-1];

        // Accept a new level only after FILTER_CYCLES consecutive differing samples
        always_comb begin
            filt_nxt_s = filt_r;
            cnt_nxt_s  = cnt_r;
            rej_s      = 1'b0;
            if (sync_s != filt_r) begin
                if (cnt_r == CNT_LAST) begin
                    filt_nxt_s = sync_s;
                    cnt_nxt_s  = {FCW{1'b0}};
                end else begin
                    cnt_nxt_s  = cnt_r + FCW'(1);
                end
            end else if (cnt_r != {FCW{1'b0}}) begin
                // Line went back before qualifying: a rejected glitch
                cnt_nxt_s = {FCW{1'b0}};
                rej_s     = 1'b1;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

        // Filter state and stability counter
        always_ff @(posedge clk) begin
            if (rst) begin
                filt_r <= 1'b1;
                cnt_r  <= {FCW{1'b0}};
            end else begin
                filt_r <= filt_nxt_s;
                cnt_r  <= cnt_nxt_s;
            end
        end

        assign filt_s[i]   = filt_r;
        assign reject_s[i] = rej_s;
    end

    // Previous filtered levels for edge and condition detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 2'b11;
        end else begin
            prev_r <= filt_s;
        end
    end

    // SDA transitions only count as START/STOP while SCL is steadily high,
    // so a simultaneous SCL+SDA change produces only the SCL edge flag.
    assign scl_rise_s =  filt_s[0] & ~prev_r[0];
    assign scl_fall_s = ~filt_s[0] &  prev_r[0];
    assign start_s    = ~filt_s[1] &  prev_r[1] & filt_s[0] & prev_r[0];
    assign stop_s     =  filt_s[1] & ~prev_r[1] & filt_s[0] & prev_r[0];

    // Bus busy from START until STOP; repeated START leaves it set
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else if (start_s) begin
            busy_r <= 1'b1;
        end else if (stop_s) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end

    // Saturating add of this cycle's rejections (0, 1 or 2)
    always_comb begin
        glitch_inc_s = {1'b0, reject_s[0]} + {1'b0, reject_s[1]};
        glitch_sum_s = {1'b0, glitch_cnt_r} + (CNT_WIDTH + 1)'(glitch_inc_s);
        if (glitch_sum_s[CNT_WIDTH]) begin
            glitch_nxt_s = {CNT_WIDTH{1'b1}};
        end else begin
            glitch_nxt_s = glitch_sum_s[CNT_WIDTH-1:0];
        end
    end

    // Glitch counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (bus.glitch_clr) begin
            glitch_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            glitch_cnt_r <= glitch_nxt_s;
        end
    end

    assign bus.scl_filt   = filt_s[0];
    assign bus.sda_filt   = filt_s[1];
    assign bus.scl_rise   = scl_rise_s;
    assign bus.scl_fall   = scl_fall_s;
    assign bus.start_det  = start_s;
    assign bus.stop_det   = stop_s;
    assign bus.bus_busy   = busy_r;
    assign bus.glitch_cnt = glitch_cnt_r;
endmodule

// File: tb/tb_i2c_pin_filter.sv
// Self-checking bench for i2c_pin_filter: a scoreboard queue of expected
// edge/condition pulses (kind + cycle) plus inline level checks per scenario.
module tb_i2c_pin_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    i2c_pin_filter_if #(.CNT_WIDTH(16)) if0 ();
    i2c_pin_filter_if #(.CNT_WIDTH(2))  if1 ();

    i2c_pin_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    i2c_pin_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    // kind: 0 scl_rise, 1 scl_fall, 2 start_det, 3 stop_det
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;
    int  exp_glitch = 0;

    // Cycle stamp: after posedge N, cyc reads N
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every flag pulse of dut0 must match the head of the queue
    always @(negedge clk) begin : mon
        logic [3:0] fl;
        ev_t        e;
        fl = {if0.stop_det, if0.start_det, if0.scl_fall, if0.scl_rise};
        for (int k = 0; k < 4; k++) begin
            if (fl[k] === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL event_unexpected: got kind %0d at cycle %0d, required no event", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        miscompares++;
                        $display("FAIL event_match: got kind %0d cycle %0d, required kind %0d cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        tick(3);
        vectors++;
        if ({if0.scl_filt, if0.sda_filt} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_filt: got %b, required 11", {if0.scl_filt, if0.sda_filt});
        end
        vectors++;
        if ({if0.scl_rise, if0.scl_fall, if0.start_det, if0.stop_det} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b, required 0000",
                     {if0.scl_rise, if0.scl_fall, if0.start_det, if0.stop_det});
        end
        vectors++;
        if (if0.bus_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, required 0", if0.bus_busy);
        end
        vectors++;
        if (if0.glitch_cnt !== 16'd0 || if1.glitch_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_glitch: got %0d/%0d, required 0/0", if0.glitch_cnt, if1.glitch_cnt);
        end
        if0.scl_in = 1'b1;
        if0.sda_in = 1'b1;
        if1.scl_in = 1'b1;
        if1.sda_in = 1'b1;
        rst = 1'b0;
        tick(8);
        exp_glitch = 0;
    endtask

    task automatic test_glitch_reject();
        if0.sda_in = 1'b0;
        tick(3);
        if0.sda_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            vectors++;
            if (if0.sda_filt !== 1'b1) begin
                miscompares++;
                $display("FAIL glitch_sda_filt: got %b, required 1", if0.sda_filt);
            end
        end
        exp_glitch = exp_glitch + 1;
        vectors++;
        if (if0.glitch_cnt !== 16'(exp_glitch)) begin
            miscompares++;
            $display("FAIL glitch_cnt: got %0d, required %0d", if0.glitch_cnt, exp_glitch);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL glitch_drained: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_start_stop();
        int p;
        p = cyc;
        if0.sda_in = 1'b0;
        expect_ev(2, p + 6);
        tick(5);
        vectors++;
        if (if0.sda_filt !== 1'b1) begin
            miscompares++;
            $display("FAIL start_early: got sda_filt %b at +5, required 1", if0.sda_filt);
        end
        tick(1);
        vectors++;
        if ({if0.sda_filt, if0.bus_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL start_at6: got sda_filt,busy %b, required 00", {if0.sda_filt, if0.bus_busy});
        end
        tick(1);
        vectors++;
        if (if0.bus_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_busy: got %b, required 1", if0.bus_busy);
        end
        tick(3);
        p = cyc;
        if0.sda_in = 1'b1;
        expect_ev(3, p + 6);
        tick(6);
        vectors++;
        if ({if0.sda_filt, if0.bus_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL stop_at6: got sda_filt,busy %b, required 11", {if0.sda_filt, if0.bus_busy});
        end
        tick(1);
        vectors++;
        if (if0.bus_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_busy: got %b, required 0", if0.bus_busy);
        end
        tick(4);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL startstop_drained: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_scl_toggle();
        int p;
        for (int i = 0; i < 4; i++) begin
            p = cyc;
            if0.scl_in = 1'b0;
            expect_ev(1, p + 6);
            tick(8);
            p = cyc;
            if0.scl_in = 1'b1;
            expect_ev(0, p + 6);
            tick(8);
        end
        tick(8);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL toggle_drained: got %0d pending events, required 0", exp_q.size());
        end
        vectors++;
        if (if0.glitch_cnt !== 16'(exp_glitch)) begin
            miscompares++;
            $display("FAIL toggle_glitch: got %0d, required %0d", if0.glitch_cnt, exp_glitch);
        end
    endtask

    task automatic test_glitch_saturate();
        int exp1;
        exp1 = 0;
        for (int g = 1; g <= 5; g++) begin
            if1.sda_in = 1'b0;
            tick(2);
            if1.sda_in = 1'b1;
            tick(6);
            exp1 = (exp1 < 3) ? exp1 + 1 : 3;
            vectors++;
            if (if1.glitch_cnt !== 2'(exp1)) begin
                miscompares++;
                $display("FAIL sat_cnt_%0d: got %0d, required %0d", g, if1.glitch_cnt, exp1);
            end
        end
        // Rejection lands on the 5th edge after the pin drop; clear on that same edge
        if1.sda_in = 1'b0;
        tick(2);
        if1.sda_in = 1'b1;
        tick(2);
        if1.glitch_clr = 1'b1;
        tick(1);
        if1.glitch_clr = 1'b0;
        vectors++;
        if (if1.glitch_cnt !== 2'd0) begin
            miscompares++;
            $display("FAIL clr_priority: got %0d, required 0", if1.glitch_cnt);
        end
        tick(4);
        if1.scl_in = 1'b0;
        if1.sda_in = 1'b0;
        tick(2);
        if1.scl_in = 1'b1;
        if1.sda_in = 1'b1;
        tick(6);
        vectors++;
        if (if1.glitch_cnt !== 2'd2) begin
            miscompares++;
            $display("FAIL both_lines: got %0d, required 2", if1.glitch_cnt);
        end
    endtask

    task automatic test_simul_and_reset();
        int p;
        p = cyc;
        if0.scl_in = 1'b0;
        if0.sda_in = 1'b0;
        expect_ev(1, p + 6);
        tick(5);
        vectors++;
        if ({if0.scl_filt, if0.sda_filt} !== 2'b11) begin
            miscompares++;
            $display("FAIL simul_early: got %b, required 11", {if0.scl_filt, if0.sda_filt});
        end
        tick(1);
        vectors++;
        if ({if0.scl_filt, if0.sda_filt, if0.start_det} !== 3'b000) begin
            miscompares++;
            $display("FAIL simul_fall: got scl,sda,start %b, required 000",
                     {if0.scl_filt, if0.sda_filt, if0.start_det});
        end
        tick(4);
        p = cyc;
        if0.scl_in = 1'b1;
        expect_ev(0, p + 6);
        tick(10);
        p = cyc;
        if0.sda_in = 1'b1;
        expect_ev(3, p + 6);
        tick(10);
        p = cyc;
        if0.sda_in = 1'b0;
        expect_ev(2, p + 6);
        tick(8);
        vectors++;
        if (if0.bus_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: got %b, required 1", if0.bus_busy);
        end
        rst = 1'b1;
        if0.scl_in = 1'b1;
        if0.sda_in = 1'b1;
        tick(1);
        vectors++;
        if ({if0.bus_busy, if0.scl_filt, if0.sda_filt} !== 3'b011) begin
            miscompares++;
            $display("FAIL mid_reset: got busy,scl,sda %b, required 011",
                     {if0.bus_busy, if0.scl_filt, if0.sda_filt});
        end
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            vectors++;
            if ({if0.stop_det, if0.bus_busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL post_reset: got stop,busy %b, required 00", {if0.stop_det, if0.bus_busy});
            end
        end
        vectors++;
        if (if0.glitch_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL post_reset_glitch: got %0d, required 0", if0.glitch_cnt);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL simul_drained: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    initial begin
        if0.scl_in     = 1'b0;
        if0.sda_in     = 1'b0;
        if0.glitch_clr = 1'b0;
        if1.scl_in     = 1'b0;
        if1.sda_in     = 1'b0;
        if1.glitch_clr = 1'b0;
        test_reset();
        test_glitch_reject();
        test_start_stop();
        test_scl_toggle();
        test_glitch_saturate();
        test_simul_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
